// File: rtl/mac_rr_scheduler.sv
// rtl/mac_rr_scheduler.sv - round-robin job scheduler sharing one MAC PE between NREQ requesters
// Optional stall timeout with error-flagged partial result: define MAC_SCHED_TIMEOUT_EN.
module mac_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int ACC_W   = 32,
  parameter int MAC_LAT = 1
`ifdef MAC_SCHED_TIMEOUT_EN
  ,
  parameter int TMO     = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    mac_clr,
  output logic [W-1:0]            mac_a,
  output logic [W-1:0]            mac_b,
  input  logic [ACC_W-1:0]        mac_prod,
  output logic                    res_valid,
  output logic [ACC_W-1:0]        res_data,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    res_err,
  input  logic                    res_ready
);

  localparam int ID_W = $clog2(NREQ);
  localparam int DR_W = $clog2(MAC_LAT + 2);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gid;
  logic [DR_W-1:0]   drain_cnt;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  int                idx;
  logic [W-1:0]      sel_a;
  logic [W-1:0]      sel_b;
  logic              sel_last;
  logic              beat;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign sel_a    = req_a[gid*W +: W];
  assign sel_b    = req_b[gid*W +: W];
  assign sel_last = req_last[gid];
  assign beat     = req_valid[gid] & req_ready[gid];

`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             abort;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gid       <= '0;
      drain_cnt <= '0;
      req_ready <= '0;
      mac_clr   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
`ifdef MAC_SCHED_TIMEOUT_EN
      res_err   <= 1'b0;
      tmo_cnt   <= '0;
      abort     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mac_a <= '0;
          mac_b <= '0;
          if (grant_found) begin
            gid     <= grant_id;
            mac_clr <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: begin
          mac_clr   <= 1'b0;
          req_ready <= NREQ'(1) << gid;
`ifdef MAC_SCHED_TIMEOUT_EN
          tmo_cnt   <= '0;
          abort     <= 1'b0;
`endif
          state     <= RUN;
        end
        RUN: begin
          if (beat) begin
            mac_a <= sel_a;
            mac_b <= sel_b;
`ifdef MAC_SCHED_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (sel_last) begin
              req_ready <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end else begin
            // Bubble: feed zeros so the PE accumulates nothing this cycle.
            mac_a <= '0;
            mac_b <= '0;
`ifdef MAC_SCHED_TIMEOUT_EN
            if (tmo_cnt == TMO_W'(TMO - 1)) begin
              req_ready <= '0;
              abort     <= 1'b1;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
        end
        DRAIN: begin
          mac_a <= '0;
          mac_b <= '0;
          if (drain_cnt == DR_W'(MAC_LAT + 1)) begin
            res_data  <= mac_prod;
            res_id    <= gid;
            res_valid <= 1'b1;
`ifdef MAC_SCHED_TIMEOUT_EN
            res_err   <= abort;
`endif
            state     <= RESP;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            rr_ptr    <= (gid == ID_W'(NREQ - 1)) ? '0 : gid + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb/tb_mac_rr_scheduler.sv - directed bench for mac_rr_scheduler with a behavioural MAC PE
// Timeout scenario switches on MAC_SCHED_TIMEOUT_EN.
module tb_mac_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int W     = 16;
  localparam int ACC_W = 32;
  localparam int LAT   = 3;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 mac_clr;
  logic [W-1:0]         mac_a;
  logic [W-1:0]         mac_b;
  logic [ACC_W-1:0]     mac_prod;
  logic                 res_valid;
  logic [ACC_W-1:0]     res_data;
  logic [1:0]           res_id;
  logic                 res_err;
  logic                 res_ready;

  int vectors = 0;
  int miscompares = 0;

  mac_rr_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_last(req_last),
    .req_ready(req_ready),
    .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_prod(mac_prod),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_err(res_err),
    .res_ready(res_ready)
  );

  // PE: one-cycle multiply-accumulate, cleared by mac_clr.
  logic signed [ACC_W-1:0] pe_acc;
  always_ff @(posedge clk) begin
    if (mac_clr) pe_acc <= '0;
    else         pe_acc <= pe_acc + $signed(mac_a) * $signed(mac_b);
  end
  assign mac_prod = pe_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    req_valid[i]      = 1'b1;
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_last[i]       = last;
  endtask

  task automatic wait_ready(input int i);
    int n;
    logic [NREQ-1:0] e;
    n = 0;
    e = NREQ'(1) << i;
    while (!req_ready[i] && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("ready_onehot_req%0d", i), req_ready, e);
  endtask

  task automatic send_beat(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    set_beat(i, a, b, last);
    wait_ready(i);
    tick();
    req_valid[i] = 1'b0;
    req_last[i]  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [ACC_W-1:0] d, input int id,
                             input logic err, input int exp_lat);
    int n;
    n = 0;
    while (!res_valid && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, res_valid, 1'b1);
    if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_data"}, res_data, d);
    check({tag, "_id"}, res_id, id);
    check({tag, "_err"}, res_err, err);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 1'b0);
  endtask

  initial begin
    logic [ACC_W-1:0] held_data;
    logic [1:0]       held_id;
    int               bad;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_last  = '0;
    res_ready = 1'b0;
    tick(); tick(); tick();

    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_mac_clr", mac_clr, 1'b0);
    check("rst_mac_ab", {mac_a, mac_b}, 32'h0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_id_err", {res_id, res_err}, 3'b000);
    rst = 1'b0;
    tick();

    // Job 1: req0, 2*3 + 4*5 + (-1)*7 = 19.
    send_beat(0, 16'd2, 16'd3, 1'b0);
    send_beat(0, 16'd4, 16'd5, 1'b0);
    send_beat(0, 16'hFFFF, 16'd7, 1'b1);
    check("j1_ready_dropped", req_ready, 4'b0000);
    wait_result("j1", 32'd19, 0, 1'b0, LAT);
    handshake("j1");

    // Jobs 2-4: req1..3 all valid, single beat (i,10); served in id order.
    for (int j = 1; j <= 3; j++) set_beat(j, 16'(j), 16'd10, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      wait_ready(j);
      tick();
      req_valid[j] = 1'b0;
      req_last[j]  = 1'b0;
      wait_result($sformatf("rr%0d", j), ACC_W'(10 * j), j, 1'b0, LAT);
      handshake($sformatf("rr%0d", j));
    end

    // Job 5: req0 with bubbles while req1 waits; rr_ptr back at 0 so req0 wins.
    set_beat(1, 16'd7, 16'd1, 1'b1);
    send_beat(0, 16'd5, 16'd5, 1'b0);
    tick(); tick(); tick();
    send_beat(0, 16'd1, 16'hFFFE, 1'b1);
    wait_result("bubble", 32'd23, 0, 1'b0, LAT);

    // Hold res_ready low: result must stay put and req1 must not be granted.
    held_data = res_data;
    held_id   = res_id;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!res_valid || res_data !== held_data || res_id !== held_id || req_ready !== 4'b0000) bad++;
    end
    check("resp_hold_stable_cycles_bad", bad, 0);
    handshake("bubble");

    // Job 6: req1 held valid throughout, now served.
    wait_ready(1);
    tick();
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    wait_result("held_req1", 32'd7, 1, 1'b0, LAT);
    handshake("held_req1");

    // Job 7: req2 reset after two beats.
    send_beat(2, 16'd3, 16'd3, 1'b0);
    send_beat(2, 16'd3, 16'd3, 1'b0);
    set_beat(2, 16'd9, 16'd9, 1'b0);
    rst = 1'b1;
    tick();
    req_valid = '0;
    req_last  = '0;
    check("midrst_req_ready", req_ready, 4'b0000);
    check("midrst_mac", {mac_clr, mac_a, mac_b}, 33'h0);
    check("midrst_res", {res_valid, res_data, res_id, res_err}, 36'h0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (res_valid !== 1'b0) bad++;
    end
    check("midrst_no_result_cycles_bad", bad, 0);
    send_beat(2, 16'd2, 16'hFFFD, 1'b1);
    wait_result("after_rst", 32'hFFFF_FFFA, 2, 1'b0, LAT);
    handshake("after_rst");

    // Job 8: req3 one beat then stalls.
    send_beat(3, 16'd3, 16'd4, 1'b0);
`ifdef MAC_SCHED_TIMEOUT_EN
    wait_result("timeout", 32'd12, 3, 1'b1, -1);
    handshake("timeout");
`else
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (res_valid !== 1'b0 || req_ready !== 4'b1000) bad++;
    end
    check("stall_holds_no_result_cycles_bad", bad, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
